// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, widths and decoded-entry type for the decode stage
//
// Purpose: opcode constants, default widths, buffer state encoding and the
//          decoded-entry struct stored in the decode output buffer.
// Ports:   none (package).
// Entry fields are sized to the largest supported widths. Narrower
// configurations zero-extend into them and truncate on the way out.

package decode_pkg;

   localparam int DEF_INST_W = 32;
   localparam int DEF_RA_W   = 5;
   localparam int DEF_ADDR_W = 16;

   localparam int RA_W_MAX   = 8;
   localparam int ADDR_W_MAX = 32;

   localparam logic [2:0] OP_0 = 3'd0;
   localparam logic [2:0] OP_1 = 3'd1;
   localparam logic [2:0] OP_2 = 3'd2;
   localparam logic [2:0] OP_3 = 3'd3;
   localparam logic [2:0] OP_4 = 3'd4;
   localparam logic [2:0] OP_5 = 3'd5;
   localparam logic [2:0] OP_6 = 3'd6;
   localparam logic [2:0] OP_7 = 3'd7;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } buf_state_t;

   typedef struct packed {
      logic [2:0]            opcode;
      logic [RA_W_MAX-1:0]   r0;
      logic [RA_W_MAX-1:0]   r1;
      logic [RA_W_MAX-1:0]   r2;
      logic [2:0]            reg_used;
      logic [ADDR_W_MAX-1:0] addr;
   } dec_entry_t;

endpackage

// File: rtl/inst_field_extract.sv
// rtl/inst_field_extract.sv - combinational instruction field decode
//
// Purpose: splits an instruction word into opcode, register addresses,
//          register-use mask and zero-extended address field.
// Ports:   inst       in   instruction word
//          opcode     out  top 3 bits of inst
//          reg_addr_0 out  first register field (always used)
//          reg_addr_1 out  second register field, zero unless opcode 2..6
//          reg_addr_2 out  third register field, zero unless opcode 4..7
//          reg_used   out  bit n set when reg_addr_n is meaningful
//          addr       out  address field, narrowed as the opcode grows

module inst_field_extract
   import decode_pkg::*;
#(
   parameter int INST_W = DEF_INST_W,
   parameter int RA_W   = DEF_RA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [INST_W-1:0] inst,
   output logic [2:0]        opcode,
   output logic [RA_W-1:0]   reg_addr_0,
   output logic [RA_W-1:0]   reg_addr_1,
   output logic [RA_W-1:0]   reg_addr_2,
   output logic [2:0]        reg_used,
   output logic [ADDR_W-1:0] addr
);

   logic use_1;
   logic use_2;

   assign opcode = inst[INST_W-1 -: 3];
   assign use_1  = (opcode >= OP_2) && (opcode <= OP_6);
   assign use_2  = (opcode >= OP_4);

   assign reg_addr_0 = inst[INST_W-4 -: RA_W];
   assign reg_addr_1 = use_1 ? inst[INST_W-4-RA_W -: RA_W]   : '0;
   assign reg_addr_2 = use_2 ? inst[INST_W-4-2*RA_W -: RA_W] : '0;
   assign reg_used   = {use_2, use_1, 1'b1};

   // Opcodes that carry more register operands give up top address bits.
   always_comb begin
      addr = inst[ADDR_W-1:0];
      case (opcode)
         OP_2, OP_3:             addr = {1'b0, inst[ADDR_W-2:0]};
         OP_4, OP_5, OP_6, OP_7: addr = {2'b00, inst[ADDR_W-3:0]};
         default:                addr = inst[ADDR_W-1:0];
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode stage with 2-entry decoded output buffer
//
// Purpose: decodes instructions on entry and buffers up to two decoded
//          entries, handing them out in acceptance order.
// Ports:   clk, rst            clock, synchronous active-high reset
//          flush               discard all buffered entries
//          in_valid/in_ready   input handshake, inst = instruction word
//          out_valid/out_ready output handshake for the head entry
//          opcode, reg_addr_0..2, reg_used, addr  head entry (zero when empty)

module decode_stage
   import decode_pkg::*;
#(
   parameter int INST_W = DEF_INST_W,
   parameter int RA_W   = DEF_RA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        opcode,
   output logic [RA_W-1:0]   reg_addr_0,
   output logic [RA_W-1:0]   reg_addr_1,
   output logic [RA_W-1:0]   reg_addr_2,
   output logic [2:0]        reg_used,
   output logic [ADDR_W-1:0] addr
);

   logic [2:0]        x_opcode;
   logic [RA_W-1:0]   x_r0;
   logic [RA_W-1:0]   x_r1;
   logic [RA_W-1:0]   x_r2;
   logic [2:0]        x_used;
   logic [ADDR_W-1:0] x_addr;

   inst_field_extract #(
      .INST_W (INST_W),
      .RA_W   (RA_W),
      .ADDR_W (ADDR_W)
   ) u_extract (
      .inst       (inst),
      .opcode     (x_opcode),
      .reg_addr_0 (x_r0),
      .reg_addr_1 (x_r1),
      .reg_addr_2 (x_r2),
      .reg_used   (x_used),
      .addr       (x_addr)
   );

   dec_entry_t dec_in;
   dec_entry_t ent0;    // head of the buffer
   dec_entry_t ent1;    // second entry, valid only in ST_FULL
   dec_entry_t head;
   buf_state_t state;
   logic       push;
   logic       pop;

   always_comb begin
      dec_in          = '0;
      dec_in.opcode   = x_opcode;
      dec_in.r0       = RA_W_MAX'(x_r0);
      dec_in.r1       = RA_W_MAX'(x_r1);
      dec_in.r2       = RA_W_MAX'(x_r2);
      dec_in.reg_used = x_used;
      dec_in.addr     = ADDR_W_MAX'(x_addr);
   end

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   // in_ready and out_valid are registered alongside the state so that
   // in_ready never depends on out_ready in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         ent0      <= '0;
         ent1      <= '0;
      end else if (flush) begin
         state     <= ST_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (push) begin
                  ent0      <= dec_in;
                  state     <= ST_ONE;
                  out_valid <= 1'b1;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  ent0 <= dec_in;
               end else if (push) begin
                  ent1     <= dec_in;
                  state    <= ST_FULL;
                  in_ready <= 1'b0;
               end else if (pop) begin
                  state     <= ST_EMPTY;
                  out_valid <= 1'b0;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so a pop is the only event.
               if (pop) begin
                  ent0     <= ent1;
                  state    <= ST_ONE;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Stale entry contents are masked so the outputs read zero when empty.
   assign head = out_valid ? ent0 : '0;

   assign opcode     = head.opcode;
   assign reg_addr_0 = RA_W'(head.r0);
   assign reg_addr_1 = RA_W'(head.r1);
   assign reg_addr_2 = RA_W'(head.r2);
   assign reg_used   = head.reg_used;
   assign addr       = ADDR_W'(head.addr);

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage

module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] inst;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  opcode;
   logic [4:0]  reg_addr_0;
   logic [4:0]  reg_addr_1;
   logic [4:0]  reg_addr_2;
   logic [2:0]  reg_used;
   logic [15:0] addr;

   int errors = 0;
   int checks = 0;

   logic [36:0] exp_q[$];

   always #5 clk = ~clk;

   decode_stage dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .inst       (inst),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .opcode     (opcode),
      .reg_addr_0 (reg_addr_0),
      .reg_addr_1 (reg_addr_1),
      .reg_addr_2 (reg_addr_2),
      .reg_used   (reg_used),
      .addr       (addr)
   );

   function automatic logic [36:0] model(input logic [31:0] w);
      logic [2:0]  op;
      logic [4:0]  r0, r1, r2;
      logic [2:0]  used;
      logic [15:0] a;
      op   = 3'(w >> 29);
      r0   = 5'(w >> 24);
      r1   = (op >= 3'd2 && op <= 3'd6) ? 5'(w >> 19) : 5'd0;
      r2   = (op >= 3'd4) ? 5'(w >> 14) : 5'd0;
      used = {op >= 3'd4, op >= 3'd2 && op <= 3'd6, 1'b1};
      if (op < 3'd2)      a = 16'(w);
      else if (op < 3'd4) a = 16'(w) & 16'h7FFF;
      else                a = 16'(w) & 16'h3FFF;
      return {op, r0, r1, r2, used, a};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check the current outputs against the scoreboard, advance the model
   // by the handshakes about to happen, then move past the next edge.
   task automatic tick(input string tag);
      logic [36:0] obs;
      int          n;
      obs = {opcode, reg_addr_0, reg_addr_1, reg_addr_2, reg_used, addr};
      n   = exp_q.size();
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(n < 2));
      chk({tag, "_out_valid"}, 64'(out_valid), 64'(n > 0));
      if (n > 0) chk({tag, "_head"}, 64'(obs), 64'(exp_q[0]));
      else       chk({tag, "_empty_zero"}, 64'(obs), 64'd0);
      if (rst || flush) begin
         exp_q.delete();
      end else begin
         if (n > 0 && out_ready) void'(exp_q.pop_front());
         if (in_valid && n < 2) exp_q.push_back(model(inst));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      inst      = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state.
      out_ready = 1'b1;
      tick("reset");

      // Op 1 example.
      in_valid = 1'b1;
      inst     = 32'h2000_ABCD;
      tick("op1_in");
      chk("op1_opcode", 64'(opcode), 64'd1);
      chk("op1_regs", 64'({reg_addr_0, reg_addr_1, reg_addr_2}), 64'd0);
      chk("op1_used", 64'(reg_used), 64'b001);
      chk("op1_addr", 64'(addr), 64'hABCD);

      // Op 2 example, accepted while op 1 drains.
      inst = 32'h5A1C_FFFF;
      tick("op2_in");
      chk("op2_r0", 64'(reg_addr_0), 64'h1A);
      chk("op2_r1", 64'(reg_addr_1), 64'h03);
      chk("op2_r2", 64'(reg_addr_2), 64'h00);
      chk("op2_used", 64'(reg_used), 64'b011);
      chk("op2_addr", 64'(addr), 64'h7FFF);

      // Op 7 example.
      inst = 32'hE108_7FFF;
      tick("op7_in");
      chk("op7_opcode", 64'(opcode), 64'd7);
      chk("op7_regs", 64'({reg_addr_0, reg_addr_1, reg_addr_2}), 64'({5'd1, 5'd0, 5'd1}));
      chk("op7_used", 64'(reg_used), 64'b101);
      chk("op7_addr", 64'(addr), 64'h3FFF);
      in_valid = 1'b0;
      tick("op7_drain");

      // Back-pressure: three pushes with the consumer stalled.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      inst      = 32'h4123_4567;
      tick("bp_a");
      inst      = 32'h8ABC_DEF0;
      tick("bp_b");
      chk("bp_full_in_ready", 64'(in_ready), 64'd0);
      inst      = 32'hC0FF_EE11;
      tick("bp_c_held");
      tick("bp_c_held2");
      out_ready = 1'b1;
      tick("bp_pop_a");
      tick("bp_pop_b_push_c");
      in_valid = 1'b0;
      tick("bp_pop_c");
      tick("bp_idle");

      // Sustained streaming, one decode per cycle.
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         inst = $urandom;
         tick("stream");
      end
      in_valid = 1'b0;
      tick("stream_tail");

      // Flush while full, with an instruction offered in the flush cycle.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      inst      = 32'h3333_3333;
      tick("fl_a");
      inst      = 32'h7777_7777;
      tick("fl_b");
      flush     = 1'b1;
      inst      = 32'hF00D_F00D;
      tick("fl_cycle");
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("fl_out_valid", 64'(out_valid), 64'd0);
      chk("fl_in_ready", 64'(in_ready), 64'd1);
      tick("fl_after");

      // Reset mid-stream in state ONE with an instruction offered.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      inst      = 32'h9999_1234;
      tick("rs_one");
      rst       = 1'b1;
      flush     = 1'b1;
      inst      = 32'hBEEF_0001;
      tick("rs_cycle");
      rst       = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      chk("rs_out_valid", 64'(out_valid), 64'd0);
      chk("rs_in_ready", 64'(in_ready), 64'd1);
      chk("rs_addr_zero", 64'(addr), 64'd0);
      tick("rs_after");

      // Random traffic with occasional flushes.
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         inst      = $urandom;
         tick("rand");
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick("final1");
      tick("final2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
